// File: rtl/acc_dvd_if.sv
// acc_dvd_if: byte bus between the host and the division accelerator
//   master (host): drives StartData, ReceiveData, Input_Data; observes OutBuffFull, ReadyToAccept, Output_Data
//   slave (acc_dvd): the reverse directions
interface acc_dvd_if;
  logic       StartData;
  logic       ReceiveData;
  logic [7:0] Input_Data;
  logic       OutBuffFull;
  logic       ReadyToAccept;
  logic [7:0] Output_Data;
  modport master (output StartData, ReceiveData, Input_Data, input OutBuffFull, ReadyToAccept, Output_Data);
  modport slave (input StartData, ReceiveData, Input_Data, output OutBuffFull, ReadyToAccept, Output_Data);
endinterface

// File: rtl/acc_dvd.sv
// acc_dvd: byte-streamed 16-bit unsigned restoring divider
//   clk   : rising-edge clock
//   rstIw : async active-high reset of input wrapper and divider
//   rstOw : async active-high reset of output wrapper
//   bus   : byte handshake (slave side), dividend/divisor in, quotient/remainder out
module acc_dvd (
  input logic       clk,
  input logic       rstIw,
  input logic       rstOw,
  acc_dvd_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t      state;
  logic        sd_r, sd_p, rd_r, rd_p;
  logic [1:0]  count;
  logic [31:0] ib;
  logic [15:0] r, q;
  logic [3:0]  it;
  logic        xfer;
  logic [31:0] ob;
  logic [1:0]  ptr;
  logic        full;
  logic        sd_ev, rd_ev, ge;
  logic [16:0] rs;
  assign sd_ev = sd_r & ~sd_p;
  assign rd_ev = rd_r & ~rd_p;
  // 17-bit shifted remainder so the compare never loses the carried-in bit
  assign rs = {r, q[15]};
  assign ge = rs >= {1'b0, ib[15:0]};
  // the 2-bit counter wraps on the 4th byte, which coincides with leaving IDLE
  assign bus.ReadyToAccept = state == IDLE;
  assign bus.OutBuffFull = full;
  // ~idx selects byte 3-idx, giving most-significant-first order
  assign bus.Output_Data = full ? ob[{~ptr, 3'b000} +: 8] : 8'h00;
  always_ff @(posedge clk or posedge rstIw)
    if (rstIw) begin
      state <= IDLE;
      sd_r <= 1'b0;
      sd_p <= 1'b0;
      count <= 2'd0;
      ib <= 32'd0;
      r <= 16'd0;
      q <= 16'd0;
      it <= 4'd0;
      xfer <= 1'b0;
    end else begin
      sd_r <= bus.StartData;
      sd_p <= sd_r;
      xfer <= 1'b0;
      case (state)
        IDLE: if (sd_ev) begin
          ib[{~count, 3'b000} +: 8] <= bus.Input_Data;
          count <= count + 2'd1;
          if (count == 2'd3) state <= LOAD;
        end
        LOAD: begin
          r <= 16'd0;
          q <= ib[31:16];
          it <= 4'd0;
          state <= CALC;
        end
        CALC: begin
          r <= ge ? rs[15:0] - ib[15:0] : rs[15:0];
          q <= {q[14:0], ge};
          it <= it + 4'd1;
          if (it == 4'd15) state <= DONE;
        end
        DONE: if (!full) begin
          xfer <= 1'b1;
          count <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  // a load always wins over a simultaneous read, which is moot since the buffer is empty then
  always_ff @(posedge clk or posedge rstOw)
    if (rstOw) begin
      rd_r <= 1'b0;
      rd_p <= 1'b0;
      ob <= 32'd0;
      ptr <= 2'd0;
      full <= 1'b0;
    end else begin
      rd_r <= bus.ReceiveData;
      rd_p <= rd_r;
      if (xfer) begin
        ob <= {q, r};
        ptr <= 2'd0;
        full <= 1'b1;
      end else if (rd_ev && full) begin
        ptr <= ptr + 2'd1;
        if (ptr == 2'd3) full <= 1'b0;
      end
    end
endmodule

// File: tb/tb_acc_dvd.sv
// tb_acc_dvd: scoreboard bench for the byte-streamed divider
module tb_acc_dvd;
  logic clk = 1'b0;
  logic rstIw = 1'b1;
  logic rstOw = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  logic rd_prev = 1'b0;
  acc_dvd_if bus();
  acc_dvd dut (.clk(clk), .rstIw(rstIw), .rstOw(rstOw), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  // a byte is taken when the host raises ReceiveData while the buffer is full
  always @(negedge clk) begin
    if (bus.ReceiveData && !rd_prev && bus.OutBuffFull) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.Output_Data);
      end else check("out_byte", 32'(bus.Output_Data), 32'(exp_q.pop_front()));
    end
    rd_prev <= bus.ReceiveData;
  end
  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    bus.Input_Data = d;
    bus.StartData = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.StartData = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask
  task automatic expect4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask
  task automatic wait_full();
    int n = 0;
    while (!bus.OutBuffFull && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.OutBuffFull) begin
      compared++;
      mismatched++;
      $display("FAIL full_timeout: got 0 expected 1");
    end
  endtask
  task automatic pulse_rd();
    @(posedge clk); #1;
    bus.ReceiveData = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.ReceiveData = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic read4();
    repeat (4) begin
      wait_full();
      pulse_rd();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.StartData = 1'b0;
    bus.ReceiveData = 1'b0;
    bus.Input_Data = 8'h00;
    #1;
    check("rst_ready", 32'(bus.ReadyToAccept), 32'(1));
    check("rst_full", 32'(bus.OutBuffFull), 32'(0));
    check("rst_data", 32'(bus.Output_Data), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstIw = 1'b0;
    rstOw = 1'b0;
    check("post_rst_ready", 32'(bus.ReadyToAccept), 32'(1));
    // normal 99/10 with exact latency check
    expect4(8'h00, 8'h09, 8'h00, 8'h09);
    send(8'h00); send(8'd99); send(8'h00);
    @(posedge clk); #1;
    bus.Input_Data = 8'd10;
    bus.StartData = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("calc_ready", 32'(bus.ReadyToAccept), 32'(0));
    bus.StartData = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("lat_not_yet", 32'(bus.OutBuffFull), 32'(0));
    @(posedge clk); #1;
    check("lat_full", 32'(bus.OutBuffFull), 32'(1));
    check("lat_ready", 32'(bus.ReadyToAccept), 32'(1));
    read4();
    check("full_drop", 32'(bus.OutBuffFull), 32'(0));
    check("idle_data", 32'(bus.Output_Data), 32'(0));
    // fifth strobe during CALC is ignored
    expect4(8'h00, 8'h09, 8'h00, 8'h09);
    op(8'h00, 8'd99, 8'h00, 8'd10);
    check("ovf_ready", 32'(bus.ReadyToAccept), 32'(0));
    send(8'd10);
    read4();
    // rstIw mid-computation aborts without producing a result
    op(8'h00, 8'd50, 8'h00, 8'd5);
    repeat (3) @(posedge clk);
    #1 rstIw = 1'b1;
    #1 check("abort_ready", 32'(bus.ReadyToAccept), 32'(1));
    @(posedge clk); #1 rstIw = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("abort_no_full", 32'(bus.OutBuffFull), 32'(0));
    // divide by zero
    expect4(8'hFF, 8'hFF, 8'h12, 8'h34);
    op(8'h12, 8'h34, 8'h00, 8'h00);
    read4();
    // rstOw discards an unread result
    op(8'h00, 8'd7, 8'h00, 8'd2);
    wait_full();
    check("rstow_pre_full", 32'(bus.OutBuffFull), 32'(1));
    #1 rstOw = 1'b1;
    #1 check("rstow_full", 32'(bus.OutBuffFull), 32'(0));
    check("rstow_data", 32'(bus.Output_Data), 32'(0));
    @(posedge clk); #1 rstOw = 1'b0;
    pulse_rd();
    check("rstow_rd_full", 32'(bus.OutBuffFull), 32'(0));
    check("rstow_rd_data", 32'(bus.Output_Data), 32'(0));
    expect4(8'hFF, 8'hFF, 8'h00, 8'h00);
    op(8'hFF, 8'hFF, 8'h00, 8'h01);
    read4();
    // backpressure: second result waits in DONE while the first is unread
    expect4(8'h00, 8'h0E, 8'h00, 8'h02);
    expect4(8'h00, 8'h1E, 8'h00, 8'h0A);
    op(8'h00, 8'd100, 8'h00, 8'd7);
    wait_full();
    op(8'h03, 8'hE8, 8'h00, 8'h21);
    repeat (30) @(posedge clk);
    #1 check("bp_ready", 32'(bus.ReadyToAccept), 32'(0));
    check("bp_full", 32'(bus.OutBuffFull), 32'(1));
    read4();
    read4();
    check("bp_drained", 32'(bus.OutBuffFull), 32'(0));
    repeat (2) @(posedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
